hamming_operand_loader: RTL and testbench

//   Byte-serial front end for the Hamming distance stage. Accepts a stream of

---
 rtl/hamming_operand_loader.sv | 95 +++++++++
 tb/tb_hamming_operand_loader.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hamming_operand_loader.sv
// Byte-serial operand loader for the Hamming distance stage.
// Bytes arrive MSB-first over a valid/ready handshake. The first WIDTH/8 bytes
// fill hex1 and the next WIDTH/8 bytes fill hex2. The completed pair is held
// until the downstream block takes it, and input stalls during that time.
module hamming_operand_loader #(
  parameter int WIDTH = 256,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             flush,
  output logic [WIDTH-1:0] hex1,
  output logic [WIDTH-1:0] hex2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] pair_cnt
);

  localparam int NB   = WIDTH / 8;
  // Keep the byte counter at least one bit wide so that a single-byte operand still elaborates.
  localparam int BC_W = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [BC_W-1:0] LAST_BYTE = BC_W'(NB - 1);

  typedef enum logic [1:0] {
    LOAD_A,
    LOAD_B,
    PRESENT
  } state_t;

  state_t          state;
  logic [BC_W-1:0] byte_cnt;

  // Accept a byte in either load state, but never while a pair is held or reset is asserted.
  assign in_ready = (state != PRESENT) && !rst;

  // Main sequencer: shift bytes into the operands, present the pair, and count each pair that is consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= LOAD_A;
      byte_cnt  <= '0;
      hex1      <= '0;
      hex2      <= '0;
      out_valid <= 1'b0;
      pair_cnt  <= '0;
    end else if (flush) begin
      state     <= LOAD_A;
      byte_cnt  <= '0;
      hex1      <= '0;
      hex2      <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        LOAD_A: begin
          if (in_valid) begin
            hex1 <= (hex1 << 8) | WIDTH'(in_data);
            if (byte_cnt == LAST_BYTE) begin
              byte_cnt <= '0;
              state    <= LOAD_B;
            end else begin
              byte_cnt <= byte_cnt + BC_W'(1);
            end
          end
        end
        LOAD_B: begin
          if (in_valid) begin
            hex2 <= (hex2 << 8) | WIDTH'(in_data);
            if (byte_cnt == LAST_BYTE) begin
              byte_cnt  <= '0;
              state     <= PRESENT;
              out_valid <= 1'b1;
            end else begin
              byte_cnt <= byte_cnt + BC_W'(1);
            end
          end
        end
        PRESENT: begin
          if (out_ready) begin
            state     <= LOAD_A;
            out_valid <= 1'b0;
            pair_cnt  <= pair_cnt + CNT_W'(1);
          end
        end
        default: begin
          state     <= LOAD_A;
          byte_cnt  <= '0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hamming_operand_loader.sv
// Self-checking bench for hamming_operand_loader.
// A reference model builds each expected operand directly from the list of bytes sent.
// A second, narrow instance with a 2-bit pair counter exercises counter wrap-around.
module tb_hamming_operand_loader;

  localparam int W   = 256;
  localparam int NB  = W / 8;
  localparam int CW  = 16;
  localparam int WW  = 32;
  localparam int WNB = WW / 8;
  localparam int WCW = 2;

  typedef logic [7:0] bq_t[$];

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          flush = 1'b0;
  logic [W-1:0]  hex1, hex2;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [CW-1:0] pair_cnt;

  logic [7:0]     w_in_data = '0;
  logic           w_in_valid = 1'b0;
  logic           w_in_ready;
  logic           w_flush = 1'b0;
  logic [WW-1:0]  w_hex1, w_hex2;
  logic           w_out_valid;
  logic           w_out_ready = 1'b0;
  logic [WCW-1:0] w_pair_cnt;

  int tests_run = 0;
  int tests_failed = 0;
  int exp_cnt = 0;
  logic [W-1:0] exp1, exp2;

  hamming_operand_loader #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .flush(flush), .hex1(hex1), .hex2(hex2),
    .out_valid(out_valid), .out_ready(out_ready), .pair_cnt(pair_cnt)
  );

  hamming_operand_loader #(.WIDTH(WW), .CNT_W(WCW)) dut_w (
    .clk(clk), .rst(rst), .in_data(w_in_data), .in_valid(w_in_valid),
    .in_ready(w_in_ready), .flush(w_flush), .hex1(w_hex1), .hex2(w_hex2),
    .out_valid(w_out_valid), .out_ready(w_out_ready), .pair_cnt(w_pair_cnt)
  );

  // Free-running clock with a 10-time-unit period
  always #5 clk = ~clk;

  // Hard stop in case the bench ever stalls
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Operand model: byte i of the operand occupies the i-th byte position counting down from the MSB
  function automatic logic [W-1:0] pack_op(input bq_t q, input int start, input int nb);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < nb; i++) r[8*(nb-1-i) +: 8] = q[start+i];
    return r;
  endfunction

  function automatic bq_t rand_bytes(input int n);
    bq_t q;
    for (int i = 0; i < n; i++) q.push_back(8'($urandom));
    return q;
  endfunction

  task automatic send_bytes(input bq_t q, input int start, input int n, input bit bubbles);
    for (int i = start; i < start + n; i++) begin
      int gaps;
      gaps = bubbles ? int'($urandom_range(0, 2)) : 0;
      repeat (gaps) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        tick();
      end
      in_valid = 1'b1;
      in_data  = q[i];
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      in_data = 8'($urandom);
      tick();
      tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_in_ready: got %b want 0", in_ready); end
      tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_out_valid: got %b want 0", out_valid); end
      tests_run++; if (hex1 !== '0 || hex2 !== '0) begin tests_failed++; $display("[TB] FAIL reset_hex: got %h / %h want 0", hex1, hex2); end
      tests_run++; if (pair_cnt !== '0) begin tests_failed++; $display("[TB] FAIL reset_pair_cnt: got %0d want 0", pair_cnt); end
    end
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_release_in_ready: got %b want 1", in_ready); end
    exp_cnt = 0;
  endtask

  task automatic test_basic();
    bq_t q;
    for (int i = 0; i < 2*NB; i++) q.push_back(8'(i));
    exp1 = pack_op(q, 0, NB);
    exp2 = pack_op(q, NB, NB);
    send_bytes(q, 0, 2*NB-1, 1'b0);
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL basic_early_valid: got %b want 0", out_valid); end
    send_bytes(q, 2*NB-1, 1, 1'b0);
    tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL basic_out_valid: got %b want 1", out_valid); end
    tests_run++; if (hex1 !== exp1) begin tests_failed++; $display("[TB] FAIL basic_hex1: got %h want %h", hex1, exp1); end
    tests_run++; if (hex2 !== exp2) begin tests_failed++; $display("[TB] FAIL basic_hex2: got %h want %h", hex2, exp2); end
    tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL basic_in_ready: got %b want 0", in_ready); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      in_valid = 1'b1;
      in_data  = 8'($urandom);
      tick();
      tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL bp_in_ready: got %b want 0", in_ready); end
      tests_run++; if (hex1 !== exp1 || hex2 !== exp2) begin tests_failed++; $display("[TB] FAIL bp_hold: got %h / %h want %h / %h", hex1, hex2, exp1, exp2); end
      tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL bp_out_valid: got %b want 1", out_valid); end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    exp_cnt++;
    tests_run++; if (pair_cnt !== CW'(exp_cnt)) begin tests_failed++; $display("[TB] FAIL bp_pair_cnt: got %0d want %0d", pair_cnt, exp_cnt); end
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL bp_out_valid_drop: got %b want 0", out_valid); end
    tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL bp_in_ready_after: got %b want 1", in_ready); end
  endtask

  task automatic test_gaps();
    bq_t q;
    for (int i = 0; i < 2*NB; i++) q.push_back(8'(i));
    send_bytes(q, 0, 2*NB, 1'b1);
    tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL gaps_out_valid: got %b want 1", out_valid); end
    tests_run++; if (hex1 !== pack_op(q, 0, NB)) begin tests_failed++; $display("[TB] FAIL gaps_hex1: got %h want %h", hex1, pack_op(q, 0, NB)); end
    tests_run++; if (hex2 !== pack_op(q, NB, NB)) begin tests_failed++; $display("[TB] FAIL gaps_hex2: got %h want %h", hex2, pack_op(q, NB, NB)); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    exp_cnt++;
    tests_run++; if (pair_cnt !== CW'(exp_cnt)) begin tests_failed++; $display("[TB] FAIL gaps_pair_cnt: got %0d want %0d", pair_cnt, exp_cnt); end
  endtask

  task automatic test_flush();
    bq_t q;
    q = rand_bytes(40);
    send_bytes(q, 0, 40, 1'b0);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'($urandom);
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    tests_run++; if (hex1 !== '0 || hex2 !== '0) begin tests_failed++; $display("[TB] FAIL flush_hex: got %h / %h want 0", hex1, hex2); end
    tests_run++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL flush_flags: got valid=%b ready=%b want 0/1", out_valid, in_ready); end
    tests_run++; if (pair_cnt !== CW'(exp_cnt)) begin tests_failed++; $display("[TB] FAIL flush_pair_cnt: got %0d want %0d", pair_cnt, exp_cnt); end
    q = rand_bytes(2*NB);
    send_bytes(q, 0, 2*NB, 1'b1);
    tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL flush_fresh_valid: got %b want 1", out_valid); end
    tests_run++; if (hex1 !== pack_op(q, 0, NB)) begin tests_failed++; $display("[TB] FAIL flush_fresh_hex1: got %h want %h", hex1, pack_op(q, 0, NB)); end
    tests_run++; if (hex2 !== pack_op(q, NB, NB)) begin tests_failed++; $display("[TB] FAIL flush_fresh_hex2: got %h want %h", hex2, pack_op(q, NB, NB)); end
    flush     = 1'b1;
    out_ready = 1'b1;
    tick();
    flush     = 1'b0;
    out_ready = 1'b0;
    tests_run++; if (pair_cnt !== CW'(exp_cnt)) begin tests_failed++; $display("[TB] FAIL flush_present_cnt: got %0d want %0d", pair_cnt, exp_cnt); end
    tests_run++; if (out_valid !== 1'b0 || hex1 !== '0) begin tests_failed++; $display("[TB] FAIL flush_present_clear: got valid=%b hex1=%h want 0", out_valid, hex1); end
  endtask

  task automatic test_reset_midload();
    bq_t q;
    q = rand_bytes(20);
    send_bytes(q, 0, 20, 1'b0);
    rst      = 1'b1;
    in_valid = 1'b1;
    tick();
    rst      = 1'b0;
    in_valid = 1'b0;
    exp_cnt  = 0;
    tests_run++; if (hex1 !== '0 || pair_cnt !== '0) begin tests_failed++; $display("[TB] FAIL midreset_clear: got hex1=%h cnt=%0d want 0", hex1, pair_cnt); end
    q = rand_bytes(2*NB);
    send_bytes(q, 0, 2*NB, 1'b0);
    tests_run++; if (hex1 !== pack_op(q, 0, NB) || hex2 !== pack_op(q, NB, NB)) begin tests_failed++; $display("[TB] FAIL midreset_pair: got %h / %h", hex1, hex2); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    exp_cnt++;
    tests_run++; if (pair_cnt !== CW'(exp_cnt)) begin tests_failed++; $display("[TB] FAIL midreset_cnt: got %0d want %0d", pair_cnt, exp_cnt); end
  endtask

  task automatic test_back_to_back();
    bq_t q;
    out_ready = 1'b1;
    for (int p = 0; p < 3; p++) begin
      q = rand_bytes(2*NB);
      send_bytes(q, 0, 2*NB, 1'b0);
      tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL b2b_valid[%0d]: got %b want 1", p, out_valid); end
      tests_run++; if (hex1 !== pack_op(q, 0, NB) || hex2 !== pack_op(q, NB, NB)) begin tests_failed++; $display("[TB] FAIL b2b_pair[%0d]: got %h / %h", p, hex1, hex2); end
      tick();
      exp_cnt++;
      tests_run++; if (pair_cnt !== CW'(exp_cnt)) begin tests_failed++; $display("[TB] FAIL b2b_cnt[%0d]: got %0d want %0d", p, pair_cnt, exp_cnt); end
    end
    out_ready = 1'b0;
  endtask

  task automatic test_wrap();
    bq_t q;
    logic [W-1:0] e1, e2;
    for (int k = 0; k < 5; k++) begin
      q = rand_bytes(2*WNB);
      foreach (q[i]) begin
        w_in_valid = 1'b1;
        w_in_data  = q[i];
        tick();
      end
      w_in_valid = 1'b0;
      e1 = pack_op(q, 0, WNB);
      e2 = pack_op(q, WNB, WNB);
      tests_run++; if (w_out_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL wrap_valid[%0d]: got %b want 1", k, w_out_valid); end
      tests_run++; if (w_hex1 !== e1[WW-1:0] || w_hex2 !== e2[WW-1:0]) begin tests_failed++; $display("[TB] FAIL wrap_pair[%0d]: got %h / %h want %h / %h", k, w_hex1, w_hex2, e1[WW-1:0], e2[WW-1:0]); end
      w_out_ready = 1'b1;
      tick();
      w_out_ready = 1'b0;
      tests_run++; if (w_pair_cnt !== WCW'((k + 1) % 4)) begin tests_failed++; $display("[TB] FAIL wrap_cnt[%0d]: got %0d want %0d", k, w_pair_cnt, (k + 1) % 4); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_gaps();
    test_flush();
    test_back_to_back();
    test_reset_midload();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
